// File: rtl/wb_trace_buffer_pkg.sv
// Shared types for the writeback trace buffer: FSM state encoding and the
// default-width trace entry layout used by software-side consumers.
package trace_pkg;

    localparam int TRACE_XLEN = 32;
    localparam int TRACE_TS_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] data;
        logic [TRACE_TS_W-1:0] ts;
    } trace_entry_t;

    localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Bundles the MEM/WB writeback tap and the valid/ready drain port of the
// trace buffer. The buffer is the slave; the pipeline/consumer side is master.
interface wb_trace_buffer_if #(
    parameter int XLEN = 32,
    parameter int TS_W = 16
);
    logic            wb_valid;
    logic            wb_regwrite;
    logic [XLEN-1:0] wb_pc;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd_pc;
    logic [4:0]      rd_rd;
    logic [XLEN-1:0] rd_data;
    logic [TS_W-1:0] rd_ts;

    modport master (
        output wb_valid, wb_regwrite, wb_pc, wb_rd, wb_data, rd_ready,
        input  rd_valid, rd_pc, rd_rd, rd_data, rd_ts
    );

    modport slave (
        input  wb_valid, wb_regwrite, wb_pc, wb_rd, wb_data, rd_ready,
        output rd_valid, rd_pc, rd_rd, rd_data, rd_ts
    );
endinterface

// File: rtl/wb_trace_buffer_ram.sv
// DEPTH-entry flop storage for trace entries: one synchronous write port and
// a combinational read port. Storage is deliberately not reset.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 69
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/wb_trace_buffer.sv
// Trigger-controlled circular trace of retired register writes with a
// valid/ready drain port. Define TRACE_TIMESTAMP_EN to store a cycle stamp per entry.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int XLEN      = 32,
    parameter int POST_TRIG = 4,
    parameter int TS_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_trace_buffer_if.slave         bus,
    input  logic                     cfg_fill_stop_i,
    input  logic                     trig_en_i,
    input  logic [XLEN-1:0]          trig_pc_i,
    input  logic                     arm_i,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0] ts;
`endif
    } entry_t;

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          we;
    logic          capture_ev;
    logic          trig_hit;
    logic          has_data;
    entry_t        wr_entry;
    entry_t        rd_entry;

    assign capture_ev = bus.wb_valid & bus.wb_regwrite & (bus.wb_rd != X0);
    assign trig_hit   = trig_en_i & (bus.wb_pc == trig_pc_i);

    assign wr_entry.pc   = bus.wb_pc;
    assign wr_entry.rd   = bus.wb_rd;
    assign wr_entry.data = bus.wb_data;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wr_entry.ts = ts_q;
    assign bus.rd_ts   = has_data ? rd_entry.ts : '0;
`else
    assign bus.rd_ts   = TS_W'(0);
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        post_cnt_d = post_cnt_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        we         = 1'b0;

        if (arm_i) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            post_cnt_d = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                ARMED, POST: begin
                    if (capture_ev) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        // A full ring drops its oldest entry to make room.
                        if (count_q == FULL) begin
                            rd_ptr_d   = rd_ptr_q + 1'b1;
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end

                        if (state_q == ARMED) begin
                            if (trig_hit) begin
                                post_cnt_d = POST_LOAD;
                                state_d    = (POST_TRIG == 0) ? FROZEN : POST;
                            end else if (cfg_fill_stop_i && (count_d == FULL)) begin
                                state_d = FROZEN;
                            end
                        end else begin
                            post_cnt_d = post_cnt_q - 1'b1;
                            if (post_cnt_q == AW'(1)) begin
                                state_d = FROZEN;
                            end
                        end
                    end
                end
                FROZEN: begin
                    if (has_data && bus.rd_ready) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            post_cnt_q <= post_cnt_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign has_data     = (count_q != '0);
    assign bus.rd_valid = (state_q == FROZEN) && has_data;
    assign bus.rd_pc    = has_data ? rd_entry.pc   : '0;
    assign bus.rd_rd    = has_data ? rd_entry.rd   : '0;
    assign bus.rd_data  = has_data ? rd_entry.data : '0;

    assign state_o    = 2'(state_q);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Two trace buffers (DEPTH 16 / POST_TRIG 1 and DEPTH 4 / POST_TRIG 0) share
// one stimulus stream and are each compared every cycle with an ordered-list model.
module tb_wb_trace_buffer;
    import trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid, wb_regwrite;
    logic [31:0] wb_pc, wb_data, trig_pc;
    logic [4:0]  wb_rd;
    logic        fill_stop, trig_en, arm, rd_ready;

    logic [1:0]  state_a, state_b;
    logic [4:0]  count_a;
    logic [2:0]  count_b;
    logic        ovf_a, ovf_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_trace_buffer_if #(.XLEN(32), .TS_W(16)) bus_a ();
    wb_trace_buffer_if #(.XLEN(32), .TS_W(16)) bus_b ();

    assign bus_a.wb_valid    = wb_valid;
    assign bus_a.wb_regwrite = wb_regwrite;
    assign bus_a.wb_pc       = wb_pc;
    assign bus_a.wb_rd       = wb_rd;
    assign bus_a.wb_data     = wb_data;
    assign bus_a.rd_ready    = rd_ready;
    assign bus_b.wb_valid    = wb_valid;
    assign bus_b.wb_regwrite = wb_regwrite;
    assign bus_b.wb_pc       = wb_pc;
    assign bus_b.wb_rd       = wb_rd;
    assign bus_b.wb_data     = wb_data;
    assign bus_b.rd_ready    = rd_ready;

    wb_trace_buffer #(.DEPTH(16), .XLEN(32), .POST_TRIG(1), .TS_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .cfg_fill_stop_i(fill_stop), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .arm_i(arm), .state_o(state_a), .count_o(count_a), .overflow_o(ovf_a)
    );

    wb_trace_buffer #(.DEPTH(4), .XLEN(32), .POST_TRIG(0), .TS_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .cfg_fill_stop_i(fill_stop), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .arm_i(arm), .state_o(state_b), .count_o(count_b), .overflow_o(ovf_b)
    );

    // Model: m_buf[k][0] is the oldest entry, m_cnt[k] entries are valid.
    int           depth_m [2] = '{16, 4};
    int           post_m  [2] = '{1, 0};
    int           m_state [2];
    int           m_cnt   [2];
    int           m_post  [2];
    bit           m_ovf   [2];
    trace_entry_t m_buf   [2][16];
    logic [15:0]  m_ts;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_cnt[k]   = 0;
            m_post[k]  = 0;
            m_ovf[k]   = 1'b0;
        end
        m_ts = '0;
    endtask

    task automatic model_step();
        bit           ev;
        trace_entry_t e;
        ev     = wb_valid && wb_regwrite && (wb_rd != 5'd0);
        e.pc   = wb_pc;
        e.rd   = wb_rd;
        e.data = wb_data;
        e.ts   = m_ts;
        for (int k = 0; k < 2; k++) begin
            if (arm) begin
                m_state[k] = 1;
                m_cnt[k]   = 0;
                m_post[k]  = 0;
                m_ovf[k]   = 1'b0;
            end else if ((m_state[k] == 1 || m_state[k] == 2) && ev) begin
                if (m_cnt[k] == depth_m[k]) begin
                    for (int j = 0; j < 15; j++) m_buf[k][j] = m_buf[k][j+1];
                    m_buf[k][depth_m[k]-1] = e;
                    m_ovf[k] = 1'b1;
                end else begin
                    m_buf[k][m_cnt[k]] = e;
                    m_cnt[k]++;
                end
                if (m_state[k] == 1) begin
                    if (trig_en && wb_pc == trig_pc) begin
                        m_post[k]  = post_m[k];
                        m_state[k] = (post_m[k] == 0) ? 3 : 2;
                    end else if (fill_stop && m_cnt[k] == depth_m[k]) begin
                        m_state[k] = 3;
                    end
                end else begin
                    m_post[k]--;
                    if (m_post[k] == 0) m_state[k] = 3;
                end
            end else if (m_state[k] == 3 && m_cnt[k] > 0 && rd_ready) begin
                $display("pop dut%0d pc=0x%0h rd=%0d data=0x%0h ts=%0d",
                         k, m_buf[k][0].pc, m_buf[k][0].rd, m_buf[k][0].data, m_buf[k][0].ts);
                for (int j = 0; j < 15; j++) m_buf[k][j] = m_buf[k][j+1];
                m_cnt[k]--;
            end
        end
        m_ts = m_ts + 16'd1;
    endtask

    task automatic check_inst(input int k, input string nm, input logic [1:0] st,
                              input logic [4:0] cnt, input logic ovf, input logic vld,
                              input logic [31:0] pc, input logic [4:0] rd,
                              input logic [31:0] data, input logic [15:0] ts);
        trace_entry_t e;
        e = (m_cnt[k] > 0) ? m_buf[k][0] : '0;
        check({nm, "_state"}, st, m_state[k]);
        check({nm, "_count"}, cnt, m_cnt[k]);
        check({nm, "_overflow"}, ovf, m_ovf[k]);
        check({nm, "_rd_valid"}, vld, (m_state[k] == 3 && m_cnt[k] > 0));
        check({nm, "_rd_pc"}, pc, e.pc);
        check({nm, "_rd_rd"}, rd, e.rd);
        check({nm, "_rd_data"}, data, e.data);
`ifdef TRACE_TIMESTAMP_EN
        check({nm, "_rd_ts"}, ts, e.ts);
`else
        check({nm, "_rd_ts"}, ts, 0);
`endif
    endtask

    task automatic check_all();
        check_inst(0, "a", state_a, count_a, ovf_a, bus_a.rd_valid, bus_a.rd_pc,
                   bus_a.rd_rd, bus_a.rd_data, bus_a.rd_ts);
        check_inst(1, "b", state_b, {2'b00, count_b}, ovf_b, bus_b.rd_valid, bus_b.rd_pc,
                   bus_b.rd_rd, bus_b.rd_data, bus_b.rd_ts);
    endtask

    task automatic cycle();
        if (!rst) model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_ev(input logic v, input logic rw, input logic [31:0] pc,
                          input logic [4:0] rd, input logic [31:0] data);
        wb_valid    = v;
        wb_regwrite = rw;
        wb_pc       = pc;
        wb_rd       = rd;
        wb_data     = data;
    endtask

    task automatic idle();
        set_ev(1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        arm = 1'b0;
    endtask

    task automatic do_arm();
        idle();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    task automatic async_reset();
        model_reset();
        #2 rst = 1'b1;
        #1 check_all();
        check("rst_state_a", state_a, 0);
        check("rst_count_a", count_a, 0);
        check("rst_valid_a", bus_a.rd_valid, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] ts0;
        idle();
        fill_stop = 1'b0;
        trig_en   = 1'b0;
        trig_pc   = 32'h0;
        rd_ready  = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;

        // Trigger at 0x4 with one post entry, then drain in order.
        trig_en = 1'b1; trig_pc = 32'h4;
        do_arm();
        for (int i = 0; i < 3; i++) begin
            set_ev(1'b1, 1'b1, 32'(i * 4), 5'(i + 1), 32'(10 + i));
            cycle();
        end
        idle();
        check("t1_state", state_a, 3);
        check("t1_count", count_a, 3);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_drain_pc", bus_a.rd_pc, i * 4);
            cycle();
        end
        check("t1_empty_valid", bus_a.rd_valid, 0);
        rd_ready = 1'b0;

        // Ring overflow on DEPTH 4, trigger on the seventh event.
        trig_pc = 32'h18; fill_stop = 1'b0;
        do_arm();
        for (int i = 0; i < 7; i++) begin
            set_ev(1'b1, 1'b1, 32'(i * 4), 5'(i + 1), $urandom);
            cycle();
        end
        idle();
        check("t2_count", count_b, 4);
        check("t2_overflow", ovf_b, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_pc", bus_b.rd_pc, 32'hC + i * 4);
            cycle();
        end
        rd_ready = 1'b0;

        // Fill-stop: DEPTH 4 freezes after the fourth event.
        trig_en = 1'b0; fill_stop = 1'b1;
        do_arm();
        for (int i = 0; i < 6; i++) begin
            set_ev(1'b1, 1'b1, 32'(i * 4), 5'(i + 1), $urandom);
            cycle();
            if (i == 3) check("t3_frozen", state_b, 3);
        end
        idle();
        check("t3_count", count_b, 4);
        check("t3_overflow", ovf_b, 0);
        check("t3_head_pc", bus_b.rd_pc, 0);
        fill_stop = 1'b0;

        // Non-events, and an event coinciding with arm.
        do_arm();
        set_ev(1'b1, 1'b1, 32'h20, 5'd0, 32'h1);  cycle();
        set_ev(1'b1, 1'b0, 32'h24, 5'd3, 32'h2);  cycle();
        set_ev(1'b0, 1'b1, 32'h28, 5'd4, 32'h3);  cycle();
        check("t4_count_a", count_a, 0);
        set_ev(1'b1, 1'b1, 32'h2C, 5'd5, 32'h4);
        arm = 1'b1;
        cycle();
        idle();
        check("t4_arm_count", count_a, 0);
        check("t4_arm_state", state_a, 1);

        // Stalled consumer keeps the head stable; one ready cycle pops once.
        trig_en = 1'b1; trig_pc = 32'h8;
        do_arm();
        for (int i = 0; i < 3; i++) begin
            set_ev(1'b1, 1'b1, 32'(i * 4), 5'(i + 1), $urandom);
            cycle();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t5_stall_pc", bus_b.rd_pc, 0);
            check("t5_stall_count", count_b, 3);
        end
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        check("t5_pop_count", count_b, 2);

        // Asynchronous reset while in POST with five entries.
        trig_pc = 32'h10;
        do_arm();
        for (int i = 0; i < 5; i++) begin
            set_ev(1'b1, 1'b1, 32'(i * 4), 5'(i + 1), $urandom);
            cycle();
        end
        idle();
        check("t6_post_state", state_a, 2);
        check("t6_post_count", count_a, 5);
        async_reset();

`ifdef TRACE_TIMESTAMP_EN
        trig_pc = 32'h40;
        do_arm();
        set_ev(1'b1, 1'b1, 32'h3C, 5'd7, 32'h77); cycle();
        idle(); cycle(); cycle();
        set_ev(1'b1, 1'b1, 32'h40, 5'd8, 32'h88); cycle();
        idle();
        ts0 = bus_b.rd_ts;
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        check("ts_delta", 16'(bus_b.rd_ts - ts0), 3);
`endif

        // Randomized traffic.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            arm = ($urandom_range(0, 47) == 0);
            if (arm) fill_stop = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) trig_en = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) trig_pc = 32'($urandom_range(0, 15) * 4);
            set_ev($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                   32'($urandom_range(0, 15) * 4),
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom);
            rd_ready = $urandom_range(0, 1);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Parametrised, synthesizable successor to the bench-side flattening of pipeline registers. Taps the MEM/WB writeback of the pipeline core and records retired register writes (pc, rd, data, optional timestamp) into a DEPTH-entry circular buffer. Capture is trigger-controlled with pre- and post-trigger history. After freezing, the buffer is drained through a valid/ready read port. It sits beside `top` as an on-chip debug observer and never back-pressures the pipeline.

Parameters:
DEPTH, 16, buffer entries; power of two, >=2
XLEN, 32, pc/data width
POST_TRIG, 4, entries captured after the trigger entry; 0..DEPTH-1
TS_W, 16, timestamp width (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wb_valid  in  1  writeback stage holds a valid instruction
wb_regwrite  in  1  instruction writes the register file
wb_pc  in  XLEN  pc of the writeback instruction
wb_rd  in  5  destination register
wb_data  in  XLEN  value written (after MtoR mux)
cfg_fill_stop  in  1  0 = ring/overwrite mode, 1 = stop when full
trig_en  in  1  enable pc-match trigger
trig_pc  in  XLEN  trigger pc
arm  in  1  single-cycle pulse: clear buffer and start capture
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts head
rd_pc  out  XLEN  head pc
rd_rd  out  5  head rd
rd_data  out  XLEN  head data
rd_ts  out  TS_W  head timestamp (0 without the feature)
state  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3
count  out  $clog2(DEPTH)+1  valid entries
overflow  out  1  sticky flag: an entry was overwritten since the last arm

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, wr_ptr=rd_ptr=0, overflow=0, rd_valid=0, post counter=0. All rd_* outputs are 0 while count==0.
- Capture event = wb_valid & wb_regwrite & (wb_rd!=0), sampled at posedge. The entry is visible at the next cycle.
- IDLE: no capture. arm -> ARMED with buffer cleared.
- ARMED: every event is written.
  - Event with trig_en & wb_pc==trig_pc: write the entry and load post_cnt=POST_TRIG. If POST_TRIG==0 -> FROZEN, else -> POST.
  - cfg_fill_stop=1 and the write makes count==DEPTH (no trigger) -> FROZEN.
- Full-buffer write in ring mode (cfg_fill_stop=0): overwrite the oldest entry, advance rd_ptr, count stays DEPTH, set overflow.
- POST: every event is written with the same full-buffer rule, post_cnt decrements. A write with post_cnt==1 -> FROZEN. Triggers in POST are ignored.
- FROZEN: no capture. rd_valid = (count!=0).
  - Pop on rd_valid & rd_ready: rd_ptr+1 mod DEPTH, count-1.
  - rd_* stay stable while rd_valid & !rd_ready.
- rd_valid is 0 in every state other than FROZEN.
- arm in any state: wr_ptr=rd_ptr=count=overflow=0 -> ARMED. arm wins over a simultaneous capture event (event discarded) and over a simultaneous pop.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count saturates at DEPTH and is never decremented below 0.
- The trigger compare uses the full XLEN width. trig_en/trig_pc are sampled every cycle, so changes take effect immediately.

Optional Feature:
TRACE_TIMESTAMP_EN
- Defined: a TS_W-bit free-running cycle counter (reset 0, wraps) is stored with each entry. rd_ts returns the stored value, i.e. counter value at the capture edge.
- Undefined: no counter and no ts storage; rd_ts tied to 0.

Decomposition:
- Package trace_pkg:
  - trace_state_e enum (IDLE, ARMED, POST, FROZEN)
  - trace_entry_t packed struct {pc, rd, data, ts} parameterised via XLEN/TS_W localparams
  - X0 constant 5'd0
- Sub-module trace_ram: DEPTH x entry flop array with one synchronous write port and an asynchronous read at rd_ptr. No reset on storage.
- FSM, pointers, counters and the optional timestamp live in wb_trace_buffer.

Test Plan:
1. DEPTH=16, POST_TRIG=1, ring; arm; trig_pc=0x4; events pc 0x0/0x4/0x8 (rd 1/2/3, data 0xA/0xB/0xC) -> FROZEN the cycle after 0x8, count=3. Drain yields 0x0, 0x4, 0x8 in order, then rd_valid=0.
2. DEPTH=4, ring, POST_TRIG=0; events pc 0x0..0x14 (6 events), trigger on the 7th at 0x18 -> buffer holds 0xC, 0x10, 0x14, 0x18; overflow=1; count=4.
3. DEPTH=4, cfg_fill_stop=1, trig_en=0; 6 events -> FROZEN after the 4th; entries 0x0..0xC; overflow=0; events 5-6 dropped.
4. Events with wb_rd=0, wb_regwrite=0 or wb_valid=0 -> count remains 0. An event coinciding with arm is discarded.
5. FROZEN with 3 entries; rd_ready low for 5 cycles -> rd_pc constant, count=3. Then rd_ready high 1 cycle -> exactly one pop, count=2.
6. Assert rst during POST with count=5 -> same delta: state=IDLE, count=0, rd_valid=0 before the next clock edge. With TRACE_TIMESTAMP_EN, arm + two events 3 cycles apart -> rd_ts difference = 3.
